// File: rtl/coeff_section_bank.sv
// -----------------------------------------------------------------------------
// coeff_section_bank
//   Double-buffered mean/stdev coefficient store for ADC sections.
//   The host writes coefficients into a shadow bank. A commit pulse copies the
//   whole shadow bank into the active bank in one edge. Each sample's section
//   index selects that section's active mean/stdev pair. The pair appears on
//   the outputs one cycle later.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   wr_en         shadow-bank write strobe
//   wr_is_std     1: write the stdev entry, 0: write the mean entry
//   wr_addr       section index of the write
//   wr_data       coefficient value to write
//   commit        copy the shadow bank to the active bank
//   in_valid      sample strobe qualifying adc_section
//   adc_section   section index of the current sample
//   mean_output   registered mean of the selected section
//   std_output    registered stdev of the selected section
//   out_valid     qualifies mean_output / std_output
//   sec_err       one-cycle pulse for an out-of-range lookup or write index
//   shadow_dirty  shadow bank has been written since the last commit
// -----------------------------------------------------------------------------
module coeff_section_bank #(
   parameter int DATA_W       = 32,
   parameter int NUM_SECTIONS = 4,
   parameter int SEC_W        = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              wr_is_std,
   input  logic [SEC_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              commit,
   input  logic              in_valid,
   input  logic [SEC_W-1:0]  adc_section,
   output logic [DATA_W-1:0] mean_output,
   output logic [DATA_W-1:0] std_output,
   output logic              out_valid,
   output logic              sec_err,
   output logic              shadow_dirty
);

   localparam int IDX_SPAN = 2 ** SEC_W;

   logic w_wr_ok;
   logic w_lkp_ok;

   // Active bank seen by the lookup. Indices with no backing section read as 0,
   // so any index value is safe to use directly.
   logic [DATA_W-1:0] w_ac_mean [IDX_SPAN];
   logic [DATA_W-1:0] w_ac_std  [IDX_SPAN];

   logic [DATA_W-1:0] r_mean;
   logic [DATA_W-1:0] r_std;
   logic              r_valid;
   logic              r_sec_err;
   logic              r_dirty;

   assign w_wr_ok  = int'(wr_addr) < NUM_SECTIONS;
   assign w_lkp_ok = int'(adc_section) < NUM_SECTIONS;

   genvar gi;
   generate
      for (gi = 0; gi < IDX_SPAN; gi++) begin : g_sec
         if (gi < NUM_SECTIONS) begin : g_used
            logic              w_hit_mean;
            logic              w_hit_std;
            logic [DATA_W-1:0] r_sh_mean;
            logic [DATA_W-1:0] r_sh_std;
            logic [DATA_W-1:0] r_ac_mean;
            logic [DATA_W-1:0] r_ac_std;

            assign w_hit_mean = wr_en && (wr_addr == SEC_W'(gi)) && !wr_is_std;
            assign w_hit_std  = wr_en && (wr_addr == SEC_W'(gi)) && wr_is_std;

            always_ff @(posedge clk) begin
               if (rst) begin
                  r_sh_mean <= '0;
                  r_sh_std  <= '0;
                  r_ac_mean <= '0;
                  r_ac_std  <= '0;
               end else begin
                  if (w_hit_mean) r_sh_mean <= wr_data;
                  if (w_hit_std)  r_sh_std  <= wr_data;
                  // A write landing on the commit edge is folded into the copy.
                  if (commit) begin
                     r_ac_mean <= w_hit_mean ? wr_data : r_sh_mean;
                     r_ac_std  <= w_hit_std  ? wr_data : r_sh_std;
                  end
               end
            end

            assign w_ac_mean[gi] = r_ac_mean;
            assign w_ac_std[gi]  = r_ac_std;
         end else begin : g_unused
            assign w_ac_mean[gi] = '0;
            assign w_ac_std[gi]  = '0;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mean    <= '0;
         r_std     <= '0;
         r_valid   <= 1'b0;
         r_sec_err <= 1'b0;
         r_dirty   <= 1'b0;
      end else begin
         // Lookup reads the active bank as it stood before this edge, so a
         // simultaneous commit is only visible to the following lookup.
         r_valid <= in_valid;
         if (in_valid) begin
            r_mean <= w_lkp_ok ? w_ac_mean[adc_section] : '0;
            r_std  <= w_lkp_ok ? w_ac_std[adc_section]  : '0;
         end
         r_sec_err <= (in_valid && !w_lkp_ok) || (wr_en && !w_wr_ok);
         if (commit)
            r_dirty <= 1'b0;
         else if (wr_en && w_wr_ok)
            r_dirty <= 1'b1;
      end
   end

   assign mean_output  = r_mean;
   assign std_output   = r_std;
   assign out_valid    = r_valid;
   assign sec_err      = r_sec_err;
   assign shadow_dirty = r_dirty;

endmodule
